// File: rtl/l0_output_writeback_controller_if.sv
// L0 read port and memory write port shared by the output write-back controller
// and its memory/L0 neighbours.
interface l0_output_writeback_controller_if #(
  parameter int Data_Bits           = 16,
  parameter int Mem_Addr_Bits       = 16,
  parameter int L0_Output_Addr_Bits = 3
);
  logic                           l0_output_rd_en;
  logic [L0_Output_Addr_Bits-1:0] l0_output_rd_addr;
  logic [Data_Bits-1:0]           l0_output_data;
  logic                           mem_wr_en;
  logic [Mem_Addr_Bits-1:0]       mem_wr_addr;
  logic [Data_Bits-1:0]           mem_wr_data;
  logic                           mem_ready;

  modport master (
    output l0_output_rd_en, l0_output_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  l0_output_data, mem_ready
  );

  modport slave (
    input  l0_output_rd_en, l0_output_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output l0_output_data, mem_ready
  );
endinterface

// File: rtl/l0_output_writeback_controller.sv
// Drains the L0 output buffer to memory after a fixed start overhead, one word per
// cycle under Mem_Ready backpressure, and publishes overhead+accepted progress.
module l0_output_writeback_controller #(
  parameter int L0_Output_Nums                       = 8,
  parameter int Writing_To_Mem_Cycles_Start_Overhead = 100,
  parameter int L0_Output_Addr_Bits                  = 3,
  parameter int Data_Bits                            = 16,
  parameter int Mem_Addr_Bits                        = 16,
  parameter int Counter_Bits                         = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               i_l0_output_status,
  input  logic [Mem_Addr_Bits-1:0] i_mem_base_addr,
  l0_output_writeback_controller_if.master bus,
  output logic [Counter_Bits-1:0]  o_output_writing_to_mem_counter,
  output logic                     o_writeback_busy,
  output logic                     o_writeback_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_OVERHEAD, ST_WRITE, ST_DONE} state_t;

  // Issued count must reach N itself, so it is one bit wider than the read index.
  localparam int Issued_Bits = $clog2(L0_Output_Nums + 1);
  localparam logic [Issued_Bits-1:0]  Issued_Max    = Issued_Bits'(L0_Output_Nums);
  localparam logic [Counter_Bits-1:0] Overhead_Last =
    Counter_Bits'(Writing_To_Mem_Cycles_Start_Overhead - 1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [Counter_Bits-1:0]  r_counter;
  logic [Mem_Addr_Bits-1:0] r_base;
  logic [Issued_Bits-1:0]   r_issued;
  logic                     r_wr_en;
  logic [Mem_Addr_Bits-1:0] r_wr_addr;
  logic [Data_Bits-1:0]     r_wr_data;

  logic w_start;
  logic w_overhead_end;
  logic w_accept;
  logic w_rd_en;
  logic w_last_accept;

  assign w_start        = (r_state == ST_IDLE) && (i_l0_output_status == 2'b11);
  assign w_overhead_end = (r_state == ST_OVERHEAD) && (r_counter == Overhead_Last);
  assign w_accept       = r_wr_en && bus.mem_ready;
  // A new read may only replace the output word once the current one is gone.
  assign w_rd_en        = (r_state == ST_WRITE) && (r_issued < Issued_Max) &&
                          (!r_wr_en || bus.mem_ready);
  assign w_last_accept  = (r_state == ST_WRITE) && w_accept && (r_issued == Issued_Max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_start)                         w_state_next = ST_OVERHEAD;
      ST_OVERHEAD: if (w_overhead_end)                  w_state_next = ST_WRITE;
      ST_WRITE:    if (w_last_accept)                   w_state_next = ST_DONE;
      ST_DONE:     if (i_l0_output_status != 2'b11)     w_state_next = ST_IDLE;
      default:                                          w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_counter <= '0;
      r_base    <= '0;
      r_issued  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_base    <= i_mem_base_addr;
            r_counter <= '0;
            r_issued  <= '0;
          end
        end
        ST_OVERHEAD: r_counter <= r_counter + Counter_Bits'(1);
        ST_WRITE: begin
          if (w_accept) r_counter <= r_counter + Counter_Bits'(1);
          if (w_rd_en) begin
            r_wr_data <= bus.l0_output_data;
            r_wr_addr <= r_base + Mem_Addr_Bits'(r_issued);
            r_wr_en   <= 1'b1;
            r_issued  <= r_issued + Issued_Bits'(1);
          end else if (w_accept) begin
            r_wr_en   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.l0_output_rd_en   = w_rd_en;
  assign bus.l0_output_rd_addr = L0_Output_Addr_Bits'(r_issued);
  assign bus.mem_wr_en         = r_wr_en;
  assign bus.mem_wr_addr       = r_wr_addr;
  assign bus.mem_wr_data       = r_wr_data;

  assign o_output_writing_to_mem_counter = r_counter;
  assign o_writeback_busy = (r_state == ST_OVERHEAD) || (r_state == ST_WRITE);
  assign o_writeback_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_l0_output_writeback_controller.sv
// Randomized bench for the L0 output write-back controller; a queue of expected
// (address, data) writes and cycle arithmetic form the reference model.
module tb_l0_output_writeback_controller;
  localparam int N  = 8;
  localparam int OH = 100;
  localparam int AB = 3;
  localparam int DB = 16;
  localparam int MA = 16;
  localparam int CB = 11;

  typedef enum int {M_ALWAYS, M_RANDOM, M_STALL} mode_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    status;
  logic [MA-1:0] base;
  logic [CB-1:0] counter;
  logic          busy;
  logic          done;
  logic [DB-1:0] l0_mem [N];

  int n_vec = 0;
  int n_err = 0;

  l0_output_writeback_controller_if #(
    .Data_Bits(DB), .Mem_Addr_Bits(MA), .L0_Output_Addr_Bits(AB)
  ) bus ();

  assign bus.l0_output_data = l0_mem[bus.l0_output_rd_addr];

  l0_output_writeback_controller #(
    .L0_Output_Nums(N), .Writing_To_Mem_Cycles_Start_Overhead(OH),
    .L0_Output_Addr_Bits(AB), .Data_Bits(DB), .Mem_Addr_Bits(MA), .Counter_Bits(CB)
  ) dut (
    .clk                             (clk),
    .rst                             (rst),
    .i_l0_output_status              (status),
    .i_mem_base_addr                 (base),
    .bus                             (bus.master),
    .o_output_writing_to_mem_counter (counter),
    .o_writeback_busy                (busy),
    .o_writeback_done                (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic observe_all_zero(input string tag);
    logic [63:0] obs;
    obs = {counter, busy, done, bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data,
           bus.l0_output_rd_en, bus.l0_output_rd_addr};
    n_vec++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL %s: outputs got %h expected all zero", tag, obs);
    end
  endtask

  // One complete transfer checked cycle by cycle; stop_acc >= 0 abandons the run
  // once that many words were accepted.
  task automatic run_transfer(input logic [MA-1:0] b, input mode_t mode, input int drop_k,
                              input int stop_acc, input bit seq_data);
    logic [MA-1:0] exp_addr[$];
    logic [DB-1:0] exp_data[$];
    logic [MA-1:0] prev_addr;
    logic [DB-1:0] prev_data;
    logic [MA-1:0] ea;
    logic [DB-1:0] ed;
    bit prev_stall;
    int k, acc, acc_inc, stalls, first_rd_k, wr_cycles, stall_left, exp_cnt;
    for (int i = 0; i < N; i++) begin
      l0_mem[i] = seq_data ? DB'(i + 1) : DB'($urandom);
      exp_addr.push_back(MA'(b + MA'(i)));
      exp_data.push_back(l0_mem[i]);
    end
    base = b;
    status = 2'b11;
    bus.mem_ready = 1'b1;
    step();
    k = 0; acc = 0; stalls = 0; first_rd_k = -1; wr_cycles = 0; stall_left = 3;
    prev_stall = 0; prev_addr = '0; prev_data = '0;
    if (drop_k == 0) status = 2'b00;
    forever begin
      if (stop_acc >= 0 && acc == stop_acc) return;
      acc_inc = 0;
      case (mode)
        M_RANDOM: bus.mem_ready = ($urandom_range(0, 3) != 0);
        M_STALL: begin
          if (acc == 3 && bus.mem_wr_en && stall_left > 0) begin
            bus.mem_ready = 1'b0;
            stall_left--;
          end else bus.mem_ready = 1'b1;
        end
        default: bus.mem_ready = 1'b1;
      endcase
      #1;
      exp_cnt = (k <= OH) ? k : OH + acc;
      n_vec++;
      if (counter !== CB'(exp_cnt)) begin
        n_err++;
        $display("FAIL counter k=%0d: got %0d expected %0d", k, counter, exp_cnt);
      end
      if (done) break;
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy k=%0d: got %b expected 1", k, busy);
      end
      if (k < OH) begin
        n_vec++;
        if (bus.l0_output_rd_en !== 1'b0 || bus.mem_wr_en !== 1'b0) begin
          n_err++;
          $display("FAIL overhead_quiet k=%0d: rd_en=%b wr_en=%b expected 0/0",
                   k, bus.l0_output_rd_en, bus.mem_wr_en);
        end
      end
      if (prev_stall) begin
        n_vec++;
        if (bus.mem_wr_en !== 1'b1 || bus.mem_wr_addr !== prev_addr ||
            bus.mem_wr_data !== prev_data) begin
          n_err++;
          $display("FAIL stall_hold k=%0d: got en=%b %h/%h expected 1 %h/%h", k,
                   bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, prev_addr, prev_data);
        end
      end
      if (bus.mem_wr_en && !bus.mem_ready) begin
        n_vec++;
        if (bus.l0_output_rd_en !== 1'b0) begin
          n_err++;
          $display("FAIL stall_no_read k=%0d: rd_en got %b expected 0", k, bus.l0_output_rd_en);
        end
        stalls++;
        prev_stall = 1;
        prev_addr = bus.mem_wr_addr;
        prev_data = bus.mem_wr_data;
      end else prev_stall = 0;
      if (bus.l0_output_rd_en && first_rd_k < 0) first_rd_k = k;
      if (bus.mem_wr_en) wr_cycles++;
      if (bus.mem_wr_en && bus.mem_ready) begin
        n_vec++;
        if (exp_addr.size() == 0) begin
          n_err++;
          $display("FAIL extra_write k=%0d: got %h/%h expected none", k,
                   bus.mem_wr_addr, bus.mem_wr_data);
        end else begin
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          if (bus.mem_wr_addr !== ea || bus.mem_wr_data !== ed) begin
            n_err++;
            $display("FAIL write%0d: got %h/%h expected %h/%h", acc,
                     bus.mem_wr_addr, bus.mem_wr_data, ea, ed);
          end
        end
        acc_inc = 1;
      end
      if (k > 2000) begin
        n_err++;
        $display("FAIL timeout: got no DONE after %0d cycles expected %0d", k, OH + N + 1);
        return;
      end
      step();
      k++;
      acc += acc_inc;
      if (k == drop_k) status = 2'b00;
    end
    n_vec++;
    if (k !== OH + N + 1 + stalls || acc !== N || exp_addr.size() != 0) begin
      n_err++;
      $display("FAIL done_timing: got k=%0d acc=%0d left=%0d expected k=%0d acc=%0d left=0",
               k, acc, exp_addr.size(), OH + N + 1 + stalls, N);
    end
    n_vec++;
    if (busy !== 1'b0 || bus.mem_wr_en !== 1'b0 || bus.l0_output_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL done_quiet: got busy=%b wr_en=%b rd_en=%b expected 0/0/0",
               busy, bus.mem_wr_en, bus.l0_output_rd_en);
    end
    if (mode == M_ALWAYS) begin
      n_vec++;
      if (first_rd_k !== OH || wr_cycles !== N) begin
        n_err++;
        $display("FAIL stream_timing: got first_rd=%0d wr_cycles=%0d expected %0d/%0d",
                 first_rd_k, wr_cycles, OH, N);
      end
    end
    if (mode == M_STALL) begin
      n_vec++;
      if (stalls !== 3) begin
        n_err++;
        $display("FAIL stall_count: got %0d expected 3", stalls);
      end
    end
  endtask

  task automatic to_idle();
    status = 2'b00;
    step();
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || counter !== CB'(OH + N) || bus.mem_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL to_idle: got done=%b busy=%b cnt=%0d wr_en=%b expected 0/0/%0d/0",
               done, busy, counter, bus.mem_wr_en, OH + N);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    status = 2'b11;
    base = 16'h1234;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < N; i++) l0_mem[i] = DB'($urandom);
    repeat (3) step();
    observe_all_zero("reset_state");
    @(negedge clk);
    status = 2'b00;
    rst = 1'b0;
    step();
    observe_all_zero("post_reset_idle");
  endtask

  task automatic test_basic_timing();
    run_transfer(MA'($urandom), M_ALWAYS, 1, -1, 0);
    to_idle();
  endtask

  task automatic test_addr_wrap();
    run_transfer(16'hFFFE, M_ALWAYS, 1, -1, 1);
    to_idle();
  endtask

  task automatic test_stall();
    run_transfer(MA'($urandom), M_STALL, 1, -1, 0);
    to_idle();
  endtask

  task automatic test_status_drop_mid_write();
    run_transfer(MA'($urandom), M_ALWAYS, OH + 3, -1, 0);
    to_idle();
  endtask

  task automatic test_reset_mid_transfer();
    run_transfer(MA'($urandom), M_ALWAYS, 1, 4, 0);
    #1;
    rst = 1'b1;
    #1;
    observe_all_zero("reset_mid_transfer");
    @(negedge clk);
    rst = 1'b0;
    run_transfer(MA'($urandom), M_ALWAYS, 1, -1, 0);
    to_idle();
  endtask

  task automatic test_status_held();
    run_transfer(MA'($urandom), M_ALWAYS, 1_000_000, -1, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0 || bus.mem_wr_en !== 1'b0 ||
          bus.l0_output_rd_en !== 1'b0 || counter !== CB'(OH + N)) begin
        n_err++;
        $display("FAIL held_done%0d: got done=%b busy=%b wr=%b rd=%b cnt=%0d expected 1/0/0/0/%0d",
                 i, done, busy, bus.mem_wr_en, bus.l0_output_rd_en, counter, OH + N);
      end
    end
    to_idle();
    run_transfer(MA'($urandom), M_ALWAYS, 1, -1, 0);
    to_idle();
  endtask

  task automatic test_random_backpressure();
    for (int r = 0; r < 4; r++) begin
      run_transfer(MA'($urandom), M_RANDOM, $urandom_range(0, OH + 12), -1, 0);
      to_idle();
    end
  endtask

  initial begin
    test_reset();
    test_basic_timing();
    test_addr_wrap();
    test_stall();
    test_status_drop_mid_write();
    test_reset_mid_transfer();
    test_status_held();
    test_random_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
